// File: rtl/idex_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : idex_issue_stage
//  Purpose  : ID/EX pipeline register for a LANES-wide issue front end.
//             Forwards a bundle of up to LANES instructions per cycle. A
//             bundle flagged for serialisation is replayed one lane per
//             cycle in ascending lane order from a shadow copy, with all
//             other lanes zeroed and decode back-pressured. Supports
//             per-lane flush, global hold, and masking of the serialisation
//             back-pressure while a fence memory request is in flight.
//
//  Ports    : clk            - clock
//             rst            - asynchronous active-high reset
//             Stall          - hold all outputs and state
//             Flush          - per-lane flush mask (overrides Stall)
//             Serialize      - bundle on `in` must issue one lane per cycle
//             Idfence_MemReq - fence memory request (registered as fence_q)
//             in / in_valid  - incoming bundle; lane i at [i*STAGE_WIDTH +:]
//             out / out_valid- registered bundle towards execute
//             IDEX_stall     - combinational back-pressure to decode
//             serial_busy    - registered, high while replaying a bundle
//
//  Revision : 1.0 - initial release
// ============================================================================
module idex_issue_stage #(
    parameter int STAGE_WIDTH = 32,
    parameter int LANES       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Stall,
    input  logic [LANES-1:0]             Flush,
    input  logic                         Serialize,
    input  logic                         Idfence_MemReq,
    input  logic [LANES*STAGE_WIDTH-1:0] in,
    input  logic [LANES-1:0]             in_valid,
    output logic [LANES*STAGE_WIDTH-1:0] out,
    output logic [LANES-1:0]             out_valid,
    output logic                         IDEX_stall,
    output logic                         serial_busy
);

    localparam int BUS_W = LANES * STAGE_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SERIAL = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [BUS_W-1:0]       shadow;
    logic [BUS_W-1:0]       shadow_nxt;
    logic [LANES-1:0]       remaining;
    logic [LANES-1:0]       remaining_nxt;
    logic [BUS_W-1:0]       out_nxt;
    logic [LANES-1:0]       out_valid_nxt;
    logic                   fence_q;

    // Lowest set bit as a one-hot mask (x & -x).
    logic [LANES-1:0]       in_lsb;
    logic [LANES-1:0]       rem_lsb;
    // "Two or more bits set": clearing the lowest set bit leaves something.
    logic                   in_multi;
    logic                   rem_multi;
    logic                   any_flush;
    logic                   start_cond;

    // Lane masks widened to payload bit granularity.
    logic [BUS_W-1:0]       in_lsb_bits;
    logic [BUS_W-1:0]       rem_lsb_bits;
    logic [BUS_W-1:0]       flush_bits;

    assign in_lsb     = in_valid & (~in_valid + LANES'(1));
    assign rem_lsb    = remaining & (~remaining + LANES'(1));
    assign in_multi   = |(in_valid & (in_valid - LANES'(1)));
    assign rem_multi  = |(remaining & (remaining - LANES'(1)));
    assign any_flush  = |Flush;
    assign start_cond = (state == ST_IDLE) && Serialize && in_multi;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign in_lsb_bits[i*STAGE_WIDTH +: STAGE_WIDTH]  = {STAGE_WIDTH{in_lsb[i]}};
            assign rem_lsb_bits[i*STAGE_WIDTH +: STAGE_WIDTH] = {STAGE_WIDTH{rem_lsb[i]}};
            assign flush_bits[i*STAGE_WIDTH +: STAGE_WIDTH]   = {STAGE_WIDTH{Flush[i]}};
        end
    endgenerate

    // Back-pressure: hold decode while a serial start is pending or while at
    // least two lanes remain to be issued. The fence only masks the signal;
    // the replay itself carries on.
    assign IDEX_stall  = ~fence_q & ((start_cond & ~any_flush) |
                                     ((state == ST_SERIAL) & rem_multi));
    assign serial_busy = (state == ST_SERIAL);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic. Priority: Flush > replay > Stall > load.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        remaining_nxt = remaining;
        out_nxt       = out;
        out_valid_nxt = out_valid;

        if (any_flush) begin
            // Unflushed lanes only take new data on a plain IDLE load;
            // otherwise they keep their current contents.
            if ((state == ST_IDLE) && !start_cond && !Stall) begin
                out_nxt       = in;
                out_valid_nxt = in_valid;
            end
            out_nxt       = out_nxt & ~flush_bits;
            out_valid_nxt = out_valid_nxt & ~Flush;
            remaining_nxt = '0;
            state_nxt     = ST_IDLE;
        end else if (state == ST_SERIAL) begin
            if (!Stall) begin
                out_nxt       = shadow & rem_lsb_bits;
                out_valid_nxt = rem_lsb;
                remaining_nxt = remaining & ~rem_lsb;
                if (!rem_multi) begin
                    state_nxt = ST_IDLE;
                end
            end
        end else if (!Stall) begin
            if (start_cond) begin
                shadow_nxt    = in;
                out_nxt       = in & in_lsb_bits;
                out_valid_nxt = in_lsb;
                remaining_nxt = in_valid & ~in_lsb;
                state_nxt     = ST_SERIAL;
            end else begin
                // Invalid lanes still load; downstream qualifies on out_valid.
                out_nxt       = in;
                out_valid_nxt = in_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            remaining <= '0;
            out       <= '0;
            out_valid <= '0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            remaining <= remaining_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fence_q <= 1'b0;
        end else begin
            fence_q <= Idfence_MemReq;
        end
    end

endmodule
`default_nettype wire

// File: doc/idex_issue_stage.md
# idex_issue_stage

Parametrised ID/EX pipeline register for a `LANES`-wide issue front end, sitting between decode/issue and the execute lanes. It forwards a bundle of up to `LANES` instructions per cycle. When decode flags a bundle for serialisation, the block replays the bundle one lane per cycle in ascending lane order, zeroing all other lanes and back-pressuring decode. It supports per-lane flush, global hold, and masking of the serialisation stall while a fence memory request is in flight.

## Interface
Parameters:
- `STAGE_WIDTH`, 32: bits per lane payload.
- `LANES`, 2: issue lanes; legal range 2..8.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Asynchronous, active-high; one clock domain only.
- `Stall`, input, 1: hold all outputs and state.
- `Flush`, input, `LANES`: per-lane flush mask.
- `Serialize`, input, 1: the bundle on `in` must issue one lane per cycle.
- `Idfence_MemReq`, input, 1: fence unit memory request. Registered internally as `fence_q`.
- `in`, input, `LANES*STAGE_WIDTH`: lane i occupies bits [i*STAGE_WIDTH +: STAGE_WIDTH].
- `in_valid`, input, `LANES`: per-lane valid.
- `out`, output, `LANES*STAGE_WIDTH`: registered payload.
- `out_valid`, output, `LANES`: registered per-lane valid.
- `IDEX_stall`, output, 1: combinational back-pressure to decode.
- `serial_busy`, output, 1: registered; high in the SERIAL state.

## Operation
**Reset.** `out`, `out_valid`, shadow buffer, `remaining` mask and `fence_q` reset to 0. State resets to IDLE. `IDEX_stall` and `serial_busy` read 0.

**Update priority per edge:** rst > Flush > serialise sequencing > Stall > load.

**IDLE, normal load.**
- Applies when not stalled and either `Serialize` = 0 or popcount(`in_valid`) ≤ 1.
- `out` <= `in`; `out_valid` <= `in_valid`.
- Invalid lanes still load their payload. Downstream qualifies lanes with `out_valid`.

**IDLE, serial start.**
- Applies when not stalled, `Serialize` = 1 and popcount(`in_valid`) ≥ 2.
- Latch `in` into the shadow buffer.
- Let k = the lowest set bit of `in_valid`. Output lane k only: its payload in lane k, `out_valid` = one-hot k, all other lanes 0.
- `remaining` <= `in_valid` with bit k cleared. Go to SERIAL.

**SERIAL.**
- Each non-stalled edge issues the lowest set bit of `remaining` from the shadow buffer, in its own lane position; other lanes are 0.
- That bit is cleared from `remaining`.
- When the bit issued is the last one, return to IDLE on the same edge.
- `in` is ignored throughout SERIAL.

**Stall.** `out`, `out_valid`, state, `remaining` and shadow all hold.

**Flush.**
- Any flush bit set: `out`/`out_valid` lanes with their flush bit set go to 0 on that edge.
- Lanes whose flush bit is clear load per the normal IDLE rule only when in IDLE and no serial start applies. Otherwise they hold.
- Any flush bit in SERIAL (or on a would-be serial-start edge) aborts the sequence: `remaining` <= 0, state <= IDLE.
- Flush overrides `Stall`.

**IDEX_stall.** IDEX_stall = ~fence_q & (S | P), where:
- S = IDLE & `Serialize` & popcount(`in_valid`) ≥ 2 & ~|`Flush`.
- P = SERIAL & popcount(`remaining`) ≥ 2.
- `fence_q` masks the stall only; sequencing proceeds regardless.

**Arithmetic.** Popcount and lowest-set-bit are combinational over `LANES` bits. No wrap-around conditions exist.

## Timing
- Latency is 1 cycle for in → out in normal mode.
- A serialised bundle with n valid lanes, unstalled:
  - Lanes appear on n consecutive edges, starting at the edge following the bundle's presentation.
  - `IDEX_stall` is high for n−1 cycles: the presentation cycle through the cycle before the second-to-last issue edge.
  - Decode therefore presents the next bundle in the cycle after the last lane issues, with no bubble.
- `serial_busy` is high from edge 1 through the cycle after edge n−1, i.e. n−1 cycles.
- `fence_q` follows `Idfence_MemReq` with 1-cycle delay and resets asynchronously.
- Each cycle of `Stall` inside SERIAL extends the sequence by one cycle and holds `IDEX_stall` at its current value.

## Test plan
- **Reset mid-sequence.** LANES=2. Assert `rst` asynchronously during SERIAL → outputs go to 0 immediately, state IDLE, `IDEX_stall` = 0. After release, the next bundle behaves normally.
- **Normal load, then stall.** `in` = {B,A}, `in_valid` = 2'b11, `Serialize` = 0 → next edge `out` = {B,A}, `out_valid` = 11. Hold `Stall` 3 cycles → `out` unchanged.
- **Basic serialisation.** `Serialize` = 1, `in_valid` = 11, `in` = {B,A} → `IDEX_stall` = 1 in cycle 0. Edge 1: `out` = {0,A}, `out_valid` = 01. Cycle 1: `IDEX_stall` = 0. Edge 2: `out` = {B,0}, `out_valid` = 10, state IDLE.
- **Sparse serialisation with stall.** LANES=4, `in_valid` = 1011, `Serialize` = 1 → issue order lanes 0, 1, 3 on three edges; `IDEX_stall` high 2 cycles. Insert `Stall` after lane 1 → lane 3 is delayed one cycle.
- **Flush abort.** During SERIAL with `remaining` ≠ 0, `Flush` = 01 → lane 0 output cleared, sequence aborted, state IDLE, `IDEX_stall` = 0 next cycle.
- **Fence masking.** `Idfence_MemReq` = 1 one cycle before a serial start → `IDEX_stall` = 0 while `fence_q` = 1, but lanes still issue one per edge in order.
